el2_dec_trigger_hit_pipe: RTL and testbench
===========================================

EL2_DEC_TRIGGER_HIT_PIPE -- requirements
Module: el2_dec_trigger_hit_pipe

Interface
REQ-001: Single clock domain; reset synchronous, active-high.
REQ-002: clk  in  1  core clock; all state updates on rising edge.
REQ-003: rst  in  1  synchronous active-high reset.
REQ-004: dec_i0_trigger_match_d  in  4  raw per-trigger match for the i0 instruction in decode.
REQ-005: dec_i0_valid_d  in  1  i0 instruction valid in decode.
REQ-006: dec_d_advance  in  1  decode-to-X transfer request.
REQ-007: dec_x_advance  in  1  X-to-R transfer request.
REQ-008: dec_flush_x  in  1  kill the X entry and any D entry transferring this cycle.
REQ-009: trigger_chain  in  4  chain bit per trigger; only bits 0 and 2 are used.
REQ-010: trigger_action  in  4  per-trigger action: 1 = enter debug mode, 0 = breakpoint exception.
REQ-011: dec_tlu_dbg_halted  in  1  core halted in debug mode; suppresses all hits.
REQ-012: tlu_trig_ack  in  1  TLU accepts the current R request.
REQ-013: dec_i0_trigger_req_r  out  1  R-stage trigger request valid.
REQ-014: dec_i0_trigger_hit_r  out  4  resolved hit vector of the R request.
REQ-015: dec_i0_trigger_action_r  out  1  1 = debug entry, 0 = breakpoint exception.
REQ-016: dec_trigger_stall  out  1  back-pressure to decode/X.
REQ-017: trigger_ack_cnt  out  8  count of acknowledged requests.

Function
REQ-018: Chain resolution at D, combinational:
- chain[0]=1: eff[0]=eff[1]=m[0]&m[1]; otherwise eff[1:0]=m[1:0].
- Pair 2/3 is identical, using chain[2].
REQ-019: eff = 0 while dec_tlu_dbg_halted=1.
REQ-020: d_action = OR over i of (eff[i] & trigger_action[i]); any debug-action hit selects debug entry.
REQ-021: dec_trigger_stall = req_r & ~tlu_trig_ack, combinational.
REQ-022: x_adv = dec_x_advance & ~dec_trigger_stall.
REQ-023: d_adv = dec_d_advance & (~x_valid | x_adv).
REQ-024: X register (x_valid, x_hit[3:0], x_action), priority order:
- dec_flush_x → x_valid=0.
- else d_adv → x_valid = dec_i0_valid_d & |eff; load x_hit=eff, x_action=d_action.
- else x_adv → x_valid=0.
- else hold.
REQ-025: When x_valid=0, x_hit and x_action hold their previous values; these are don't-care.
REQ-026: R register loads when x_valid & x_adv & ~dec_flush_x: req_r=1, hit_r=x_hit, action_r=x_action.
REQ-027: Simultaneous ack and load in the same cycle → the new request is loaded; no bubble.
REQ-028: Ack without load → req_r=0; hit_r and action_r clear to 0.
REQ-029: Ack with req_r=0 → ignored.
REQ-030: R is not affected by dec_flush_x or dec_tlu_dbg_halted; an issued request persists until acked.
REQ-031: Latency: a hit decoded in cycle N with no stall and no flush gives req_r=1 in cycle N+2.
REQ-032: trigger_ack_cnt increments on each cycle with req_r & tlu_trig_ack; saturates at 255.
REQ-033: dec_x_advance with x_valid=0 produces no request.

Reset
REQ-034: rst=1 clears x_valid, x_hit, x_action, req_r, hit_r, action_r and trigger_ack_cnt to 0.
REQ-035: Outputs during and after reset: req_r=0, hit_r=0, action_r=0, stall=0, cnt=0.
REQ-036: rst overrides every concurrent input, including tlu_trig_ack, flush and advance.
REQ-037: Reset asserted with a pending request drops the request without acknowledgement.

Verification
REQ-038: Unchained single hit: match=4'b0100, action=4'b0000, valid=1, both advances=1, ack at N+2 → req_r=1 at N+2, hit_r=4'b0100, action_r=0; cnt=1 one cycle after ack.
REQ-039: Chain check: chain=4'b0001, match=4'b0001 → no request. Then match=4'b0011 → hit_r=4'b0011.
REQ-040: Back-pressure: two consecutive hits (4'b0001, then 4'b1000), ack withheld for 3 cycles:
- stall=1 throughout; second hit held in X.
- Ack cycle loads 4'b1000 with no bubble.
REQ-041: Flush: hit in X with dec_flush_x=1 → no request.
- Same-cycle D transfer is also killed.
- An existing R request remains asserted until acked.
REQ-042: Debug/halt: action=4'b0010, match=4'b0010 → action_r=1. With dbg_halted=1, match=4'b1111 → no request.
REQ-043: Saturation: 260 acked requests → cnt=255. rst mid-request → req_r=0 next cycle and cnt=0.

Source files
------------

// File: rtl/el2_dec_trigger_hit_pipe.sv
// -----------------------------------------------------------------------------
// el2_dec_trigger_hit_pipe
//
// Carries debug-trigger hits for the i0 instruction from decode (D), through
// execute (X), to the retire-stage request (R) that the TLU consumes.
//
// At D the raw per-trigger matches are chain-resolved. Triggers 0/1 form one
// pair and 2/3 form another. In a chained pair both triggers must match, and
// then both report a hit. Every hit is suppressed while the core is halted in
// debug mode. A D instruction with at least one resolved hit occupies the X
// slot. It then moves into the R request register, which holds until the TLU
// acknowledges it. A pending, unacknowledged request back-pressures X and D.
//
// Ports
//   clk                      in   core clock, rising edge
//   rst                      in   synchronous active-high reset
//   dec_i0_trigger_match_d   in   [3:0] raw trigger match for i0 in D
//   dec_i0_valid_d           in   i0 valid in D
//   dec_d_advance            in   D->X transfer request
//   dec_x_advance            in   X->R transfer request
//   dec_flush_x              in   kill X and any D entry moving this cycle
//   trigger_chain            in   [3:0] chain bits (only 0 and 2 are meaningful)
//   trigger_action           in   [3:0] 1 = debug entry, 0 = breakpoint
//   dec_tlu_dbg_halted       in   core halted in debug mode
//   tlu_trig_ack             in   TLU accepts the current R request
//   dec_i0_trigger_req_r     out  R request valid
//   dec_i0_trigger_hit_r     out  [3:0] resolved hit vector of the R request
//   dec_i0_trigger_action_r  out  1 = debug entry, 0 = breakpoint exception
//   dec_trigger_stall        out  back-pressure to D/X
//   trigger_ack_cnt          out  [7:0] saturating count of acknowledged requests
// -----------------------------------------------------------------------------
module el2_dec_trigger_hit_pipe (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] dec_i0_trigger_match_d,
  input  logic       dec_i0_valid_d,
  input  logic       dec_d_advance,
  input  logic       dec_x_advance,
  input  logic       dec_flush_x,
  input  logic [3:0] trigger_chain,
  input  logic [3:0] trigger_action,
  input  logic       dec_tlu_dbg_halted,
  input  logic       tlu_trig_ack,
  output logic       dec_i0_trigger_req_r,
  output logic [3:0] dec_i0_trigger_hit_r,
  output logic       dec_i0_trigger_action_r,
  output logic       dec_trigger_stall,
  output logic [7:0] trigger_ack_cnt
);

  // Payload carried by the X slot and by the R request.
  typedef struct packed {
    logic [3:0] hit;
    logic       action;
  } trig_entry_t;

  // ---------------------------------------------------------------------------
  // D stage: chain resolution and action selection
  // ---------------------------------------------------------------------------
  logic [3:0] eff_hit;
  logic       d_action;

  // Chain bits 1 and 3 have no partner trigger, so they do nothing. This
  // signal only marks them as intentionally unused.
  logic unused_chain;
  assign unused_chain = ^{trigger_chain[3], trigger_chain[1]};

  always_comb begin
    // NOTE: every variable gets a default on entry, so no path through the
    // block can leave a value held, and no latch can be inferred.
    eff_hit = dec_i0_trigger_match_d;

    if (trigger_chain[0]) begin
      eff_hit[1:0] = {2{&dec_i0_trigger_match_d[1:0]}};
    end
    if (trigger_chain[2]) begin
      eff_hit[3:2] = {2{&dec_i0_trigger_match_d[3:2]}};
    end

    if (dec_tlu_dbg_halted) begin
      eff_hit = 4'b0000;
    end
  end

  // Any debug-action hit takes precedence over breakpoint hits.
  assign d_action = |(eff_hit & trigger_action);

  // ---------------------------------------------------------------------------
  // Pipeline handshakes
  // ---------------------------------------------------------------------------
  logic        x_valid_q, x_valid_d;
  trig_entry_t x_ent_q,   x_ent_d;
  logic        req_q,     req_d;
  trig_entry_t r_ent_q,   r_ent_d;
  logic [7:0]  cnt_q,     cnt_d;

  logic x_adv;
  logic d_adv;
  logic r_load;
  logic r_ack;

  assign dec_trigger_stall = req_q & ~tlu_trig_ack;
  assign x_adv             = dec_x_advance & ~dec_trigger_stall;
  assign d_adv             = dec_d_advance & (~x_valid_q | x_adv);

  // A flush kills the X entry before it can reach R. It does not touch a
  // request that has already been issued.
  assign r_load = x_valid_q & x_adv & ~dec_flush_x;
  assign r_ack  = req_q & tlu_trig_ack;

  // ---------------------------------------------------------------------------
  // Next-state logic
  // ---------------------------------------------------------------------------
  always_comb begin
    x_valid_d = x_valid_q;
    x_ent_d   = x_ent_q;

    if (dec_flush_x) begin
      x_valid_d = 1'b0;
    end else if (d_adv) begin
      // Only an instruction that actually hit a trigger occupies X. The payload
      // loads regardless and is ignored while x_valid is low.
      x_valid_d = dec_i0_valid_d & (|eff_hit);
      x_ent_d   = '{hit: eff_hit, action: d_action};
    end else if (x_adv) begin
      x_valid_d = 1'b0;
    end
  end

  always_comb begin
    req_d   = req_q;
    r_ent_d = r_ent_q;
    cnt_d   = cnt_q;

    // A load in the same cycle as an ack replaces the acked request directly,
    // so back-to-back hits leave no bubble.
    if (r_load) begin
      req_d   = 1'b1;
      r_ent_d = x_ent_q;
    end else if (r_ack) begin
      req_d   = 1'b0;
      r_ent_d = '0;
    end

    if (r_ack && (cnt_q != 8'hFF)) begin
      cnt_d = cnt_q + 8'd1;
    end
  end

  // ---------------------------------------------------------------------------
  // State registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    // NOTE: non-blocking assignments make every register sample the
    // pre-edge value of every other register, whatever the statement order.
    if (rst) begin
      x_valid_q <= 1'b0;
      // NOTE: the X payload is don't-care while x_valid is low, but it is
      // still cleared so that nothing in the block leaves reset unknown.
      x_ent_q   <= '0;
      req_q     <= 1'b0;
      r_ent_q   <= '0;
      cnt_q     <= 8'h00;
    end else begin
      x_valid_q <= x_valid_d;
      x_ent_q   <= x_ent_d;
      req_q     <= req_d;
      r_ent_q   <= r_ent_d;
      cnt_q     <= cnt_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Outputs
  // ---------------------------------------------------------------------------
  assign dec_i0_trigger_req_r    = req_q;
  assign dec_i0_trigger_hit_r    = r_ent_q.hit;
  assign dec_i0_trigger_action_r = r_ent_q.action;
  assign trigger_ack_cnt         = cnt_q;

endmodule

// File: tb/tb_el2_dec_trigger_hit_pipe.sv
// -----------------------------------------------------------------------------
// Testbench for el2_dec_trigger_hit_pipe.
//
// The reference model holds the X slot and the R request as queues of
// {hit, action} entries, each with at most one element, and moves entries
// between them by the transfer rules. Expected outputs come from the queue
// contents: the request is present when the R queue is non-empty, and the hit
// and action outputs are zero when it is empty.
// -----------------------------------------------------------------------------
module tb_el2_dec_trigger_hit_pipe;

  logic       clk = 1'b0;
  logic       rst;
  logic [3:0] dec_i0_trigger_match_d;
  logic       dec_i0_valid_d;
  logic       dec_d_advance;
  logic       dec_x_advance;
  logic       dec_flush_x;
  logic [3:0] trigger_chain;
  logic [3:0] trigger_action;
  logic       dec_tlu_dbg_halted;
  logic       tlu_trig_ack;
  logic       dec_i0_trigger_req_r;
  logic [3:0] dec_i0_trigger_hit_r;
  logic       dec_i0_trigger_action_r;
  logic       dec_trigger_stall;
  logic [7:0] trigger_ack_cnt;

  el2_dec_trigger_hit_pipe dut (
    .clk                     (clk),
    .rst                     (rst),
    .dec_i0_trigger_match_d  (dec_i0_trigger_match_d),
    .dec_i0_valid_d          (dec_i0_valid_d),
    .dec_d_advance           (dec_d_advance),
    .dec_x_advance           (dec_x_advance),
    .dec_flush_x             (dec_flush_x),
    .trigger_chain           (trigger_chain),
    .trigger_action          (trigger_action),
    .dec_tlu_dbg_halted      (dec_tlu_dbg_halted),
    .tlu_trig_ack            (tlu_trig_ack),
    .dec_i0_trigger_req_r    (dec_i0_trigger_req_r),
    .dec_i0_trigger_hit_r    (dec_i0_trigger_hit_r),
    .dec_i0_trigger_action_r (dec_i0_trigger_action_r),
    .dec_trigger_stall       (dec_trigger_stall),
    .trigger_ack_cnt         (trigger_ack_cnt)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout, expected test completion");
    $fatal(1, "watchdog expired");
  end

  // ---------------------------------------------------------------------------
  // Checking
  // ---------------------------------------------------------------------------
  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // ---------------------------------------------------------------------------
  // Stimulus record
  // ---------------------------------------------------------------------------
  typedef struct {
    logic [3:0] match;
    logic       valid;
    logic       da;
    logic       xa;
    logic       flush;
    logic [3:0] chain;
    logic [3:0] action;
    logic       halted;
    logic       ack;
    logic       rst;
  } stim_t;

  function automatic stim_t idle();
    stim_t s;
    s.match  = 4'b0000;
    s.valid  = 1'b0;
    s.da     = 1'b1;
    s.xa     = 1'b1;
    s.flush  = 1'b0;
    s.chain  = 4'b0000;
    s.action = 4'b0000;
    s.halted = 1'b0;
    s.ack    = 1'b0;
    s.rst    = 1'b0;
    return s;
  endfunction

  function automatic stim_t hit(input logic [3:0] m);
    stim_t s = idle();
    s.match = m;
    s.valid = 1'b1;
    return s;
  endfunction

  // ---------------------------------------------------------------------------
  // Reference model
  // ---------------------------------------------------------------------------
  typedef struct packed {
    logic [3:0] hit;
    logic       act;
  } req_t;

  req_t xq[$];
  req_t rq[$];
  int   m_cnt;

  function automatic logic [3:0] resolve(input logic [3:0] m, input logic [3:0] ch,
                                         input logic halted);
    logic [3:0] e;
    logic       both;
    e = m;
    for (int p = 0; p < 4; p += 2) begin
      if (ch[p]) begin
        both     = m[p] & m[p+1];
        e[p]     = both;
        e[p+1]   = both;
      end
    end
    if (halted) e = 4'b0000;
    return e;
  endfunction

  task automatic model_reset();
    xq.delete();
    rq.delete();
    m_cnt = 0;
  endtask

  task automatic model_check(input logic ack);
    logic       exp_req;
    logic [3:0] exp_hit;
    logic       exp_act;
    exp_req = (rq.size() != 0);
    exp_hit = exp_req ? rq[0].hit : 4'b0000;
    exp_act = exp_req ? rq[0].act : 1'b0;
    check("req_r",    dec_i0_trigger_req_r,    exp_req);
    check("hit_r",    dec_i0_trigger_hit_r,    exp_hit);
    check("action_r", dec_i0_trigger_action_r, exp_act);
    check("stall",    dec_trigger_stall,       exp_req && !ack);
    check("ack_cnt",  trigger_ack_cnt,         m_cnt);
  endtask

  task automatic model_step(input stim_t s);
    logic [3:0] eff;
    logic       x_full, stall, ack_taken, x_go, x_moves, d_moves;
    req_t       moving;
    if (s.rst) begin
      model_reset();
      return;
    end
    eff       = resolve(s.match, s.chain, s.halted);
    x_full    = (xq.size() != 0);
    stall     = (rq.size() != 0) && !s.ack;
    ack_taken = (rq.size() != 0) && s.ack;
    x_go      = s.xa && !stall;
    x_moves   = x_full && x_go;
    d_moves   = s.da && (!x_full || x_go);
    moving    = x_full ? xq[0] : '0;

    if (x_moves && !s.flush) begin
      rq.delete();
      rq.push_back(moving);
    end else if (ack_taken) begin
      rq.delete();
    end
    if (ack_taken && m_cnt < 255) m_cnt++;

    if (s.flush) begin
      xq.delete();
    end else if (d_moves) begin
      xq.delete();
      if (s.valid && eff != 4'b0000) xq.push_back('{hit: eff, act: ((eff & s.action) != 4'b0000)});
    end else if (x_moves) begin
      xq.delete();
    end
  endtask

  // Apply one cycle of stimulus at the falling edge. Check the outputs against
  // the model, advance the model, and return at the next falling edge.
  task automatic cyc(input stim_t s);
    rst                    = s.rst;
    dec_i0_trigger_match_d = s.match;
    dec_i0_valid_d         = s.valid;
    dec_d_advance          = s.da;
    dec_x_advance          = s.xa;
    dec_flush_x            = s.flush;
    trigger_chain          = s.chain;
    trigger_action         = s.action;
    dec_tlu_dbg_halted     = s.halted;
    tlu_trig_ack           = s.ack;
    #1;
    model_check(s.ack);
    model_step(s);
    @(negedge clk);
  endtask

  // ---------------------------------------------------------------------------
  // Test sequence
  // ---------------------------------------------------------------------------
  initial begin
    stim_t s;

    s = idle();
    s.rst = 1'b1;
    rst                    = 1'b1;
    dec_i0_trigger_match_d = 4'b0000;
    dec_i0_valid_d         = 1'b0;
    dec_d_advance          = 1'b1;
    dec_x_advance          = 1'b1;
    dec_flush_x            = 1'b0;
    trigger_chain          = 4'b0000;
    trigger_action         = 4'b0000;
    dec_tlu_dbg_halted     = 1'b0;
    tlu_trig_ack           = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    model_reset();
    check("reset_req",   dec_i0_trigger_req_r,    1'b0);
    check("reset_hit",   dec_i0_trigger_hit_r,    4'b0000);
    check("reset_act",   dec_i0_trigger_action_r, 1'b0);
    check("reset_stall", dec_trigger_stall,       1'b0);
    check("reset_cnt",   trigger_ack_cnt,         8'd0);

    // Unchained single hit: the request appears two cycles later.
    cyc(hit(4'b0100));
    cyc(idle());
    check("single_req", dec_i0_trigger_req_r,    1'b1);
    check("single_hit", dec_i0_trigger_hit_r,    4'b0100);
    check("single_act", dec_i0_trigger_action_r, 1'b0);
    s = idle(); s.ack = 1'b1;
    cyc(s);
    check("single_cnt", trigger_ack_cnt, 8'd1);

    // Chaining: a half-matched pair yields no hit, and a full pair hits both.
    s = hit(4'b0001); s.chain = 4'b0001;
    cyc(s);
    cyc(idle());
    check("chain_half_req", dec_i0_trigger_req_r, 1'b0);
    cyc(idle());
    s = hit(4'b0011); s.chain = 4'b0001;
    cyc(s);
    cyc(idle());
    check("chain_full_req", dec_i0_trigger_req_r, 1'b1);
    check("chain_full_hit", dec_i0_trigger_hit_r, 4'b0011);
    s = idle(); s.ack = 1'b1;
    cyc(s);

    // Back-pressure: the second hit waits in X while the ack is withheld.
    cyc(hit(4'b0001));
    cyc(hit(4'b1000));
    for (int i = 0; i < 3; i++) begin
      cyc(idle());
      check("bp_stall", dec_trigger_stall,    1'b1);
      check("bp_hit",   dec_i0_trigger_hit_r, 4'b0001);
    end
    s = idle(); s.ack = 1'b1;
    cyc(s);
    check("bp_noBubble_req", dec_i0_trigger_req_r, 1'b1);
    check("bp_noBubble_hit", dec_i0_trigger_hit_r, 4'b1000);
    cyc(s);

    // Flush: kill X and the D transfer in the same cycle.
    cyc(hit(4'b0100));
    s = hit(4'b0010); s.flush = 1'b1;
    cyc(s);
    cyc(idle());
    check("flush_req_a", dec_i0_trigger_req_r, 1'b0);
    cyc(idle());
    check("flush_req_b", dec_i0_trigger_req_r, 1'b0);
    // Flush with a request already issued: that request survives.
    cyc(hit(4'b0001));
    cyc(hit(4'b0010));
    s = idle(); s.flush = 1'b1;
    cyc(s);
    check("flush_keep_req", dec_i0_trigger_req_r, 1'b1);
    check("flush_keep_hit", dec_i0_trigger_hit_r, 4'b0001);
    cyc(idle());
    check("flush_keep_req2", dec_i0_trigger_req_r, 1'b1);
    s = idle(); s.ack = 1'b1;
    cyc(s);
    cyc(idle());
    check("flush_after_req", dec_i0_trigger_req_r, 1'b0);

    // Debug action, then suppression while halted.
    s = hit(4'b0010); s.action = 4'b0010;
    cyc(s);
    cyc(idle());
    check("dbg_act", dec_i0_trigger_action_r, 1'b1);
    check("dbg_hit", dec_i0_trigger_hit_r,    4'b0010);
    s = idle(); s.ack = 1'b1;
    cyc(s);
    s = hit(4'b1111); s.halted = 1'b1; s.action = 4'b0010;
    cyc(s);
    cyc(idle());
    check("halted_req", dec_i0_trigger_req_r, 1'b0);
    cyc(idle());

    // Saturation of the ack counter.
    for (int i = 0; i < 260; i++) begin
      s = hit(4'b0001); s.ack = 1'b1;
      cyc(s);
    end
    check("sat_cnt", trigger_ack_cnt, 8'd255);
    cyc(idle());
    check("pend_req", dec_i0_trigger_req_r, 1'b1);
    // Reset overrides a pending request and a concurrent ack.
    s = hit(4'b0001); s.ack = 1'b1; s.flush = 1'b1; s.rst = 1'b1;
    cyc(s);
    check("rst_req", dec_i0_trigger_req_r, 1'b0);
    check("rst_hit", dec_i0_trigger_hit_r, 4'b0000);
    check("rst_cnt", trigger_ack_cnt,      8'd0);

    // Randomized traffic against the model.
    for (int i = 0; i < 3000; i++) begin
      s.match  = 4'($urandom);
      s.valid  = ($urandom_range(0, 3) != 0);
      s.da     = ($urandom_range(0, 7) != 0);
      s.xa     = ($urandom_range(0, 7) != 0);
      s.flush  = ($urandom_range(0, 15) == 0);
      s.chain  = 4'($urandom);
      s.action = 4'($urandom);
      s.halted = ($urandom_range(0, 15) == 0);
      s.ack    = ($urandom_range(0, 2) != 0);
      s.rst    = ($urandom_range(0, 99) == 0);
      cyc(s);
    end
    cyc(idle());

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
